// File: rtl/traffic_pkg.sv
// Shared types and helpers for the phase sequencer.
//   state_e   : vehicle interval (all-red clearance, green, amber)
//   walk_e    : pedestrian sub-state within a green
//   next_phase: round-robin pick of the next eligible phase
package traffic_pkg;

  // Upper bound on phase count supported by next_phase().
  localparam int unsigned MaxPhases = 32;
  localparam int unsigned MaxPhW    = $clog2(MaxPhases);

  typedef enum logic [1:0] {
    StAllRed,
    StGreen,
    StAmber
  } state_e;

  typedef enum logic [1:0] {
    WalkDont,
    WalkOn,
    WalkFdw
  } walk_e;

  // First eligible phase scanning cur+1 .. num-1, then wrapping through 0 .. cur.
  // Falls back to phase 0 when nothing is eligible.
  function automatic int unsigned next_phase(input int unsigned            cur,
                                             input logic [MaxPhases-1:0]   elig,
                                             input int unsigned            num);
    int unsigned idx;
    logic        found;
    next_phase = 0;
    found      = 1'b0;
    for (int unsigned k = 1; k <= MaxPhases; k++) begin
      if (k <= num) begin
        idx = (cur + k) % num;
        if (!found && elig[idx[MaxPhW-1:0]]) begin
          found      = 1'b1;
          next_phase = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable tick-driven down-counter.
//   clk_i/rst_ni : clock, async active-low reset (reset acts as a load of ResetVal)
//   tick_i       : count enable
//   load_i       : reload with load_val_i; the following cycle never counts a tick
//   done_o       : high on the cycle of the final tick (and on any tick once expired)
module phase_timer #(
  parameter int unsigned CntW     = 8,
  parameter int unsigned ResetVal = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            tick_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  // Marks the entry cycle of an interval, which must not consume a tick.
  logic            fresh_q, fresh_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= CntW'(ResetVal);
      fresh_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    fresh_d = 1'b0;
    if (load_i) begin
      cnt_d   = load_val_i;
      fresh_d = 1'b1;
    end else if (!fresh_q && tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Saturating at zero lets a held green leave on any later tick.
  assign done_o = tick_i & ~fresh_q & (cnt_q <= CntW'(1));

endmodule

// File: rtl/phase_sequencer.sv
// Intersection sequencer for NUM_PHASES phases; phase 0 is the rest phase.
//   clk_i, not_reset_i     : clock, async active-low reset
//   tick_i                 : timing enable, all intervals count its pulses
//   phase_request_i        : vehicle requests (bit 0 ignored)
//   walk_request_i         : pedestrian requests
//   green/amber/red_o      : vehicle lights per phase
//   walk/flashing_dont_walk/dont_walk_o : pedestrian indications per phase
//   active_phase_o         : phase owning right of way
//   walk_request_waiting_o : OR of latched walk requests
module phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = 4,
  parameter int unsigned GREEN_TICKS   = 8,
  parameter int unsigned AMBER_TICKS   = 3,
  parameter int unsigned ALL_RED_TICKS = 1,
  parameter int unsigned WALK_TICKS    = 3,
  parameter int unsigned FDW_TICKS     = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                          clk_i,
  input  logic                          not_reset_i,
  input  logic                          tick_i,
  input  logic [NUM_PHASES-1:0]         phase_request_i,
  input  logic [NUM_PHASES-1:0]         walk_request_i,
  output logic [NUM_PHASES-1:0]         green_o,
  output logic [NUM_PHASES-1:0]         amber_o,
  output logic [NUM_PHASES-1:0]         red_o,
  output logic [NUM_PHASES-1:0]         walk_o,
  output logic [NUM_PHASES-1:0]         flashing_dont_walk_o,
  output logic [NUM_PHASES-1:0]         dont_walk_o,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase_o,
  output logic                          walk_request_waiting_o
);

  localparam int unsigned PW = $clog2(NUM_PHASES);

  state_e                state_q, state_d;
  walk_e                 wstate_q, wstate_d;
  logic [PW-1:0]         active_q, active_d;
  logic [NUM_PHASES-1:0] veh_q, veh_d;
  logic [NUM_PHASES-1:0] wlatch_q, wlatch_d;
  logic [NUM_PHASES-1:0] elig;
  logic [MaxPhases-1:0]  elig_ext;
  logic                  others_elig;
  logic                  veh_done, walk_done;
  logic [CNT_W-1:0]      veh_load_val, walk_load_val;

  always_ff @(posedge clk_i or negedge not_reset_i) begin
    if (!not_reset_i) begin
      state_q  <= StAllRed;
      wstate_q <= WalkDont;
      active_q <= PW'(NUM_PHASES - 1);
      veh_q    <= '0;
      wlatch_q <= '0;
    end else begin
      state_q  <= state_d;
      wstate_q <= wstate_d;
      active_q <= active_d;
      veh_q    <= veh_d;
      wlatch_q <= wlatch_d;
    end
  end

  // Phase 0 is always a valid destination when leaving another phase.
  always_comb begin
    elig = veh_q | wlatch_q;
    elig[0] = (|(veh_q | wlatch_q)) | (active_q != '0);
    others_elig = |(elig & ~NUM_PHASES'(1));
  end

  assign elig_ext = MaxPhases'(elig);

  always_comb begin
    state_d  = state_q;
    wstate_d = wstate_q;
    active_d = active_q;
    veh_d    = veh_q | phase_request_i;
    veh_d[0] = 1'b0;
    wlatch_d = wlatch_q | walk_request_i;
    unique case (state_q)
      StAllRed: begin
        if (veh_done) begin
          state_d  = StGreen;
          active_d = PW'(next_phase(32'(active_q), elig_ext, NUM_PHASES));
          // Clearing after the OR absorbs a request landing on this cycle.
          veh_d[active_d] = 1'b0;
          if (wlatch_d[active_d]) begin
            wstate_d           = WalkOn;
            wlatch_d[active_d] = 1'b0;
          end
        end
      end
      StGreen: begin
        if (walk_done && wstate_q == WalkOn)  wstate_d = WalkFdw;
        if (walk_done && wstate_q == WalkFdw) wstate_d = WalkDont;
        if (veh_done && ((active_q != '0) || others_elig)) begin
          state_d  = StAmber;
          wstate_d = WalkDont;
        end
      end
      StAmber: begin
        if (veh_done) state_d = StAllRed;
      end
      default: state_d = StAllRed;
    endcase
  end

  always_comb begin
    unique case (state_d)
      StGreen: veh_load_val = CNT_W'(GREEN_TICKS);
      StAmber: veh_load_val = CNT_W'(AMBER_TICKS);
      default: veh_load_val = CNT_W'(ALL_RED_TICKS);
    endcase
    walk_load_val = (wstate_d == WalkOn) ? CNT_W'(WALK_TICKS) : CNT_W'(FDW_TICKS);
  end

  phase_timer #(
    .CntW     (CNT_W),
    .ResetVal (ALL_RED_TICKS)
  ) u_veh_timer (
    .clk_i      (clk_i),
    .rst_ni     (not_reset_i),
    .tick_i     (tick_i),
    .load_i     (state_d != state_q),
    .load_val_i (veh_load_val),
    .done_o     (veh_done)
  );

  phase_timer #(
    .CntW     (CNT_W),
    .ResetVal (WALK_TICKS)
  ) u_walk_timer (
    .clk_i      (clk_i),
    .rst_ni     (not_reset_i),
    .tick_i     (tick_i),
    .load_i     (wstate_d != wstate_q),
    .load_val_i (walk_load_val),
    .done_o     (walk_done)
  );

  always_comb begin
    logic [NUM_PHASES-1:0] g, a, w, f;
    g = '0;
    a = '0;
    w = '0;
    f = '0;
    if (state_q == StGreen)  g[active_q] = 1'b1;
    if (state_q == StAmber)  a[active_q] = 1'b1;
    if (wstate_q == WalkOn)  w[active_q] = 1'b1;
    if (wstate_q == WalkFdw) f[active_q] = 1'b1;
    green_o              = g;
    amber_o              = a;
    red_o                = ~(g | a);
    walk_o               = w;
    flashing_dont_walk_o = f;
    dont_walk_o          = ~(w | f);
  end

  assign active_phase_o         = active_q;
  assign walk_request_waiting_o = |wlatch_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboarded bench: the script pushes each expected output snapshot with the
// cycle it should appear on; a monitor pops one entry per observed output change.
module tb_phase_sequencer;

  localparam int AR = 0, G = 1, A = 2;
  localparam int DW = 0, W = 1, F = 2;

  logic       clk = 1'b0;
  logic       not_reset = 1'b0;
  logic       tick = 1'b1;
  logic [2:0] preq = '0;
  logic [2:0] wreq = '0;
  logic [2:0] green, amber, red, walk, fdw, dw;
  logic [1:0] active;
  logic       waiting;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [20:0] snap;
    int          t;
  } exp_t;
  exp_t sb_q[$];

  phase_sequencer #(
    .NUM_PHASES    (3),
    .GREEN_TICKS   (6),
    .AMBER_TICKS   (2),
    .ALL_RED_TICKS (1),
    .WALK_TICKS    (2),
    .FDW_TICKS     (2),
    .CNT_W         (8)
  ) dut (
    .clk_i                  (clk),
    .not_reset_i            (not_reset),
    .tick_i                 (tick),
    .phase_request_i        (preq),
    .walk_request_i         (wreq),
    .green_o                (green),
    .amber_o                (amber),
    .red_o                  (red),
    .walk_o                 (walk),
    .flashing_dont_walk_o   (fdw),
    .dont_walk_o            (dw),
    .active_phase_o         (active),
    .walk_request_waiting_o (waiting)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] mk(input int st, input int act, input int ws, input bit wt);
    logic [2:0] g, a, w, f;
    g = '0; a = '0; w = '0; f = '0;
    if (st == G) g[act] = 1'b1;
    if (st == A) a[act] = 1'b1;
    if (ws == W) w[act] = 1'b1;
    if (ws == F) f[act] = 1'b1;
    return {g, a, ~(g | a), w, f, ~(w | f), 2'(act), wt};
  endfunction

  // One light per phase in each group, and only the active phase off red.
  function automatic bit inv_ok(input logic [20:0] s);
    logic [2:0] g, a, r, w, f, d;
    logic [1:0] act;
    bit ok;
    {g, a, r, w, f, d, act} = s[20:1];
    ok = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (int'(g[p]) + int'(a[p]) + int'(r[p]) != 1) ok = 1'b0;
      if (int'(w[p]) + int'(f[p]) + int'(d[p]) != 1) ok = 1'b0;
      if ((g[p] | a[p] | w[p] | f[p]) && (p != int'(act))) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic push(input int st, input int act, input int ws, input bit wt, input int t);
    exp_t e;
    e.snap = mk(st, act, ws, wt);
    e.t    = t;
    sb_q.push_back(e);
  endtask

  // Returns 1 ns after the clock edge that starts cycle n.
  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  logic [20:0] last_snap, cur_snap;
  exp_t        got_e;
  initial begin
    last_snap = 'x;
    forever begin
      @(negedge clk or negedge not_reset);
      #1;
      cur_snap = {green, amber, red, walk, fdw, dw, active, waiting};
      if (cur_snap !== last_snap) begin
        last_snap = cur_snap;
        n_vec++;
        if (!inv_ok(cur_snap)) begin
          n_err++;
          $display("FAIL invariant cycle %0d: got %h, required one-hot lights", cyc, cur_snap);
        end
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change cycle %0d: got %h, required no change", cyc, cur_snap);
        end else begin
          got_e = sb_q.pop_front();
          if (cur_snap !== got_e.snap) begin
            n_err++;
            $display("FAIL snapshot cycle %0d: got %h, required %h", cyc, cur_snap, got_e.snap);
          end
          if (got_e.t >= 0) begin
            n_vec++;
            if (cyc != got_e.t) begin
              n_err++;
              $display("FAIL timing snap %h: got cycle %0d, required cycle %0d",
                       got_e.snap, cyc, got_e.t);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset, then idle on phase 0 well past 50 cycles.
    push(AR, 2, DW, 0, -1);
    push(G, 0, DW, 0, 5);
    at_cycle(3);
    not_reset = 1'b1;

    // Phase 2 request: phase 1 skipped, back to phase 0.
    push(A, 0, DW, 0, 62);  push(AR, 0, DW, 0, 65); push(G, 2, DW, 0, 67);
    push(A, 2, DW, 0, 74);  push(AR, 2, DW, 0, 77); push(G, 0, DW, 0, 79);
    at_cycle(60); preq = 3'b100;
    at_cycle(61); preq = 3'b000;

    // Phases 1 and 2 together, plus a phase 0 walk requested during phase 1.
    push(A, 0, DW, 0, 86);  push(AR, 0, DW, 0, 89); push(G, 1, DW, 0, 91);
    push(G, 1, DW, 1, 94);  push(A, 1, DW, 1, 98);  push(AR, 1, DW, 1, 101);
    push(G, 2, DW, 1, 103); push(A, 2, DW, 1, 110); push(AR, 2, DW, 1, 113);
    push(G, 0, W, 0, 115);  push(G, 0, F, 0, 118);  push(G, 0, DW, 0, 121);
    at_cycle(80); preq = 3'b110;
    at_cycle(81); preq = 3'b000;
    at_cycle(93); wreq = 3'b001;
    at_cycle(94); wreq = 3'b000;

    // Walk request on the cycle that moves phase 0 into green: served, absorbed.
    push(A, 0, DW, 0, 132); push(AR, 0, DW, 0, 135); push(G, 1, DW, 0, 137);
    push(A, 1, DW, 0, 144); push(AR, 1, DW, 0, 147); push(G, 0, W, 0, 149);
    push(G, 0, F, 0, 152);  push(G, 0, DW, 0, 155);
    at_cycle(130); preq = 3'b010;
    at_cycle(131); preq = 3'b000;
    at_cycle(148); wreq = 3'b001;
    at_cycle(149); wreq = 3'b000;

    // Next phase 0 service has no walk; tick stalls for 4 cycles in phase 2 green.
    push(A, 0, DW, 0, 162); push(AR, 0, DW, 0, 165); push(G, 2, DW, 0, 167);
    push(A, 2, DW, 0, 178); push(AR, 2, DW, 0, 181); push(G, 0, DW, 0, 183);
    at_cycle(160); preq = 3'b100;
    at_cycle(161); preq = 3'b000;
    at_cycle(169); tick = 1'b0;
    at_cycle(173); tick = 1'b1;

    // Reset during phase 1 amber drops pending phase 2 requests.
    push(A, 0, DW, 0, 192); push(AR, 0, DW, 0, 195); push(G, 1, DW, 0, 197);
    push(G, 1, DW, 1, 201); push(A, 1, DW, 1, 204); push(AR, 2, DW, 0, 205);
    push(G, 0, DW, 0, 209);
    at_cycle(190); preq = 3'b010;
    at_cycle(191); preq = 3'b000;
    at_cycle(200); preq = 3'b100; wreq = 3'b100;
    at_cycle(201); preq = 3'b000; wreq = 3'b000;
    at_cycle(205); not_reset = 1'b0;
    at_cycle(207); not_reset = 1'b1;

    at_cycle(250);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events: got %0d unseen, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised intersection sequencer for N signal phases. It replaces the fixed four-approach controller FSM: it times green, amber and all-red intervals and serves optional phases only on request. Pedestrian walk cycles run inside a phase's green. It sits between the divided clock/tick source and the per-phase hex light decoders. Phase 0 is the main street and rests in green when no other phase is requested.

## Interface
- NUM_PHASES, 4: number of phases, ≥2; phase 0 is main/rest phase
- GREEN_TICKS, 8: minimum green duration in ticks; must be ≥ WALK_TICKS+FDW_TICKS
- AMBER_TICKS, 3: amber duration in ticks
- ALL_RED_TICKS, 1: all-red clearance in ticks
- WALK_TICKS, 3: walk duration in ticks
- FDW_TICKS, 3: flashing don't-walk duration in ticks
- CNT_W, 8: timer width; must hold max(all *_TICKS)
- clk  in  1  system clock
- not_reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle timing enable; all durations count tick pulses
- phase_request  in  NUM_PHASES  vehicle requests, active high, synchronous, debounced; bit 0 ignored
- walk_request  in  NUM_PHASES  pedestrian requests per phase, active high, synchronous
- green, amber, red  out  NUM_PHASES each  one-hot-per-phase vehicle lights
- walk, flashing_dont_walk, dont_walk  out  NUM_PHASES each  pedestrian indications
- active_phase  out  $clog2(NUM_PHASES)  phase currently owning right of way
- walk_request_waiting  out  1  OR of all latched walk requests (debug)

## Operation
- States: ALL_RED, GREEN, AMBER. Outputs are decoded combinationally from registered state (Moore).
- Per phase p, exactly one of green[p]/amber[p]/red[p] is high, and exactly one of walk[p]/flashing_dont_walk[p]/dont_walk[p] is high. Only active_phase may show green or amber.
- Request latches: veh_latch[p] is set by phase_request[p]; walk_latch[p] is set by walk_request[p]. Both are sticky.
  - veh_latch[p] clears on the cycle phase p enters GREEN.
  - walk_latch[p] clears on the cycle its walk starts.
  - A request arriving on its own clear cycle is absorbed (treated as served).
- GREEN entry: if walk_latch[p] is set, sub-sequence WALK (WALK_TICKS) → FDW (FDW_TICKS) → DONT_WALK runs from the first green cycle. Otherwise dont_walk stays high.
  - A walk request arriving after the walk window has passed stays latched for the next service of p.
- GREEN exit: after GREEN_TICKS, go to AMBER if any other phase is eligible; otherwise hold GREEN (only possible for phase 0).
  - A phase q≠0 is eligible if veh_latch[q] or walk_latch[q] is set.
  - Phase 0 is eligible if any walk_latch or veh_latch is set, or unconditionally once leaving another phase.
- Non-zero phase exit: always leaves GREEN after GREEN_TICKS.
- AMBER → ALL_RED after AMBER_TICKS.
- ALL_RED → GREEN of the next phase after ALL_RED_TICKS. Next phase is the first eligible phase scanning active_phase+1 … NUM_PHASES-1, wrapping to 0.
- Reset: state ALL_RED, active_phase = NUM_PHASES-1, latches cleared, timer loaded. All red=1, all dont_walk=1, all other outputs 0, walk_request_waiting=0. The first transition therefore lands on phase 0.
- Reset mid-interval aborts immediately to the reset state. No amber is forced.

## Timing
- An interval of N ticks ends on the cycle of the Nth tick pulse after entry. The state changes on the next clock edge.
- The timer reloads on every state or walk-substate change. The entry cycle does not count a tick even if tick is high.
- Request-to-latch latency is 1 cycle. walk_request_waiting follows 1 cycle after walk_request.
- With no tick pulses, the state is frozen. Requests are still latched.
- Flashing is the display's job; flashing_dont_walk is a steady level.

## Structure
- Package traffic_pkg: state enum (ALL_RED, GREEN, AMBER), walk enum (DONT_WALK, WALK, FDW), and function next_phase(cur, eligible_vec).
- Sub-module phase_timer: loadable down-counter of width CNT_W, enabled by tick, with a done flag. Instantiate one for the vehicle interval and one for the walk interval.

## Test plan
Common setup: NUM_PHASES=3, GREEN=6, AMBER=2, ALL_RED=1, WALK=2, FDW=2, tick every cycle.
- Reset then idle: ALL_RED for 1 tick, then phase 0 green. It stays green for ≥50 cycles. red[2:1]=2'b11 and all dont_walk stay high.
- Pulse phase_request[2] during phase 0 green: phase 0 completes 6 ticks of green, then 2 amber, then 1 all-red. Phase 2 then gets green (phase 1 skipped), and afterwards the sequence returns to phase 0.
- Pulse walk_request[0] during phase 1 green: at phase 0 entry, walk[0]=1 for 2 ticks, then flashing_dont_walk[0] for 2 ticks, then dont_walk. walk_request_waiting drops on walk entry.
- walk_request[0] asserted on the same cycle phase 0 enters green: walk runs and the latch is absorbed. No second walk on the next service.
- Requests on phases 1 and 2 simultaneously: service order is 0→1→2→0, each green lasting exactly 6 ticks.
- Assert not_reset=0 during amber of phase 1: all outputs return to reset values asynchronously, latches clear, and phase 0 green follows 1 tick after release.
